// File: rtl/axis_frame_gen.sv
// AXI-Stream raster frame generator: IMG_W x IMG_H 8-bit pixels, SOF on tuser[0],
// end-of-line on tlast, four deterministic test patterns, full backpressure support.
package img_processing_pkg;
    localparam int IMG_W            = 64;
    localparam int IMG_H            = 48;
    localparam int AXIS_TDATA_WIDTH = 8;
    localparam int AXIS_TUSER_WIDTH = 1;
endpackage

module axis_frame_gen #(
    parameter int IMG_W       = img_processing_pkg::IMG_W,
    parameter int IMG_H       = img_processing_pkg::IMG_H,
    parameter int TDATA_WIDTH = img_processing_pkg::AXIS_TDATA_WIDTH,
    parameter int TUSER_WIDTH = img_processing_pkg::AXIS_TUSER_WIDTH,
    parameter int H_BLANK     = 0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [1:0]             pattern_sel,
    input  logic [15:0]            lfsr_seed,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [BW-1:0] B_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK} state_t;

    state_t          state, state_n;
    logic [XW-1:0]   x, x_n;
    logic [YW-1:0]   y, y_n;
    logic [BW-1:0]   blank_cnt, blank_n;
    logic [1:0]      pat, pat_n;
    logic            cont, cont_n;
    logic [15:0]     lfsr, lfsr_n, lfsr_step, seed_eff;
    logic            frame_done_n;
    logic [15:0]     frame_cnt_n;
    logic [7:0]      x8, y8, pix;
    logic            xfer;

    assign seed_eff  = (lfsr_seed == 16'h0000) ? 16'hACE1 : lfsr_seed;
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign xfer      = (state == S_ACTIVE) && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            blank_cnt  <= '0;
            pat        <= '0;
            cont       <= 1'b0;
            lfsr       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            blank_cnt  <= blank_n;
            pat        <= pat_n;
            cont       <= cont_n;
            lfsr       <= lfsr_n;
            frame_done <= frame_done_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        blank_n      = blank_cnt;
        pat_n        = pat;
        cont_n       = cont;
        lfsr_n       = lfsr;
        frame_done_n = 1'b0;
        frame_cnt_n  = frame_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ACTIVE;
                    pat_n   = pattern_sel;
                    cont_n  = continuous;
                    lfsr_n  = seed_eff;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            S_ACTIVE: begin
                if (xfer) begin
                    lfsr_n = lfsr_step;
                    if (x != X_LAST) begin
                        x_n = x + 1'b1;
                    end else begin
                        x_n     = '0;
                        blank_n = '0;
                        if (y != Y_LAST) begin
                            y_n = y + 1'b1;
                            if (H_BLANK > 0) state_n = S_HBLANK;
                        end else begin
                            y_n          = '0;
                            frame_done_n = 1'b1;
                            frame_cnt_n  = frame_cnt + 1'b1;
                            // Restart needs the frame-start latch and the request still held now,
                            // so dropping continuous mid-frame ends the run after this frame.
                            if (cont && continuous) begin
                                pat_n   = pattern_sel;
                                cont_n  = continuous;
                                lfsr_n  = seed_eff;
                                state_n = (H_BLANK > 0) ? S_HBLANK : S_ACTIVE;
                            end else begin
                                state_n = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (blank_cnt == B_LAST) state_n = S_ACTIVE;
                else                     blank_n = blank_cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign x8 = 8'(x);
    assign y8 = 8'(y);

    always_comb begin
        unique case (pat)
            2'b00:   pix = x8;
            2'b01:   pix = y8;
            2'b10:   pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            default: pix = lfsr[7:0];
        endcase
    end

    assign m_axis_tvalid = (state == S_ACTIVE);
    assign m_axis_tlast  = m_axis_tvalid && (x == X_LAST);
    assign busy          = (state != S_IDLE);

    always_comb begin
        m_axis_tdata    = '0;
        m_axis_tuser    = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata[7:0] = pix;
            m_axis_tuser[0]   = (x == '0) && (y == '0);
        end
    end
endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: a 4x3 instance and a 16x16 instance with line blanking.
module tb_axis_frame_gen;
    localparam int AW = 4, AH = 3;
    localparam int BWD = 16, BHT = 16, BHB = 2;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       last;
    } beat_t;

    beat_t sbq[$];
    int    checks = 0;
    int    failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_start, a_cont, a_tready;
    logic [1:0]  a_sel;
    logic [15:0] a_seed;
    logic [7:0]  a_tdata;
    logic [0:0]  a_tuser;
    logic        a_tlast, a_tvalid, a_busy, a_done;
    logic [15:0] a_cnt;

    logic        b_rstn, b_start, b_cont, b_tready;
    logic [1:0]  b_sel;
    logic [15:0] b_seed;
    logic [9:0]  b_tdata;
    logic [1:0]  b_tuser;
    logic        b_tlast, b_tvalid, b_busy, b_done;
    logic [15:0] b_cnt;

    axis_frame_gen #(.IMG_W(AW), .IMG_H(AH), .TDATA_WIDTH(8), .TUSER_WIDTH(1), .H_BLANK(0)) dut_a (
        .aclk(clk), .aresetn(a_rstn), .start(a_start), .continuous(a_cont),
        .pattern_sel(a_sel), .lfsr_seed(a_seed), .m_axis_tdata(a_tdata), .m_axis_tuser(a_tuser),
        .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
        .busy(a_busy), .frame_done(a_done), .frame_cnt(a_cnt)
    );

    axis_frame_gen #(.IMG_W(BWD), .IMG_H(BHT), .TDATA_WIDTH(10), .TUSER_WIDTH(2), .H_BLANK(BHB)) dut_b (
        .aclk(clk), .aresetn(b_rstn), .start(b_start), .continuous(b_cont),
        .pattern_sel(b_sel), .lfsr_seed(b_seed), .m_axis_tdata(b_tdata), .m_axis_tuser(b_tuser),
        .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
        .busy(b_busy), .frame_done(b_done), .frame_cnt(b_cnt)
    );

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic test_reset;
        a_rstn = 1'b0; b_rstn = 1'b0; a_start = 1'b1; b_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_tvalid, a_tlast, a_busy, a_done} !== 4'b0 || a_tdata !== 8'h00 || a_tuser !== 1'b0 || a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_a: tvalid=%b tlast=%b busy=%b done=%b tdata=%h tuser=%b cnt=%0d, required all zero",
                     a_tvalid, a_tlast, a_busy, a_done, a_tdata, a_tuser, a_cnt);
        end
        checks++;
        if ({b_tvalid, b_tlast, b_busy, b_done} !== 4'b0 || b_tdata !== 10'h000 || b_tuser !== 2'b00 || b_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_b: tvalid=%b tlast=%b busy=%b done=%b tdata=%h tuser=%b cnt=%0d, required all zero",
                     b_tvalid, b_tlast, b_busy, b_done, b_tdata, b_tuser, b_cnt);
        end
        @(posedge clk); #1;
        a_rstn = 1'b1; b_rstn = 1'b1; a_start = 1'b0; b_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hramp;
        beat_t e;
        int cyc, done_seen;
        sbq.delete();
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                sbq.push_back('{8'(x), (x == 0 && y == 0), (x == AW - 1)});
        a_sel = 2'b00; a_cont = 1'b0; a_tready = 1'b1; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 0; done_seen = 0;
        while (sbq.size() > 0 && cyc < 50) begin
            @(negedge clk); cyc++;
            if (a_done) done_seen++;
            if (a_tvalid && a_tready) begin
                e = sbq.pop_front();
                checks++;
                if (a_tdata !== e.d || a_tuser[0] !== e.sof || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL hramp_beat cyc%0d: got d=%h sof=%b last=%b, expected d=%h sof=%b last=%b",
                             cyc, a_tdata, a_tuser[0], a_tlast, e.d, e.sof, e.last);
                end
            end
        end
        checks++;
        if (sbq.size() != 0 || cyc != AW * AH) begin
            failures++;
            $display("FAIL hramp_rate: %0d beats left after %0d cycles, required 0 left after %0d", sbq.size(), cyc, AW * AH);
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL hramp_early_done: frame_done seen %0d times mid-frame, required 0", done_seen);
        end
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b1 || a_cnt !== 16'd1) begin
            failures++;
            $display("FAIL hramp_done: frame_done=%b frame_cnt=%0d, required 1 and 1", a_done, a_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL hramp_idle: done=%b busy=%b tvalid=%b, required 0 0 0", a_done, a_busy, a_tvalid);
        end
    endtask

    task automatic test_vramp_backpressure;
        beat_t e;
        int cyc;
        logic held, hu, hl;
        logic [7:0] hd;
        sbq.delete();
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                sbq.push_back('{8'(y), (x == 0 && y == 0), (x == AW - 1)});
        a_sel = 2'b01; a_cont = 1'b0; a_tready = 1'b0; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 0; held = 1'b0; hd = '0; hu = 1'b0; hl = 1'b0;
        while (sbq.size() > 0 && cyc < 300) begin
            a_tready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            a_sel = 2'($urandom_range(0, 3));
            @(negedge clk); cyc++;
            if (held) begin
                checks++;
                if (a_tvalid !== 1'b1 || a_tdata !== hd || a_tuser[0] !== hu || a_tlast !== hl) begin
                    failures++;
                    $display("FAIL vramp_hold cyc%0d: got v=%b d=%h sof=%b last=%b, required v=1 d=%h sof=%b last=%b",
                             cyc, a_tvalid, a_tdata, a_tuser[0], a_tlast, hd, hu, hl);
                end
            end
            held = a_tvalid && !a_tready;
            hd = a_tdata; hu = a_tuser[0]; hl = a_tlast;
            if (a_tvalid && a_tready) begin
                e = sbq.pop_front();
                checks++;
                if (a_tdata !== e.d || a_tuser[0] !== e.sof || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL vramp_beat cyc%0d: got d=%h sof=%b last=%b, expected d=%h sof=%b last=%b",
                             cyc, a_tdata, a_tuser[0], a_tlast, e.d, e.sof, e.last);
                end
            end
            if (sbq.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        a_tready = 1'b1;
        checks++;
        if (sbq.size() != 0 || a_done !== 1'b1 || a_cnt !== 16'd2) begin
            failures++;
            $display("FAIL vramp_done: left=%0d frame_done=%b frame_cnt=%0d, required 0 1 2", sbq.size(), a_done, a_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lfsr_stall;
        beat_t e;
        int cyc;
        logic held;
        logic [7:0] hd;
        logic [15:0] s;
        sbq.delete();
        s = 16'hACE1;
        for (int i = 0; i < AW * AH; i++) begin
            sbq.push_back('{s[7:0], (i == 0), ((i % AW) == AW - 1)});
            s = lfsr_adv(s);
        end
        a_sel = 2'b11; a_seed = 16'h0000; a_cont = 1'b0; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 0; held = 1'b0; hd = '0;
        while (sbq.size() > 0 && cyc < 100) begin
            a_tready = (cyc < 5) ? 1'b0 : 1'b1;
            @(negedge clk); cyc++;
            if (held) begin
                checks++;
                if (a_tvalid !== 1'b1 || a_tdata !== hd) begin
                    failures++;
                    $display("FAIL lfsr_stall cyc%0d: got v=%b d=%h, required v=1 d=%h", cyc, a_tvalid, a_tdata, hd);
                end
            end
            held = a_tvalid && !a_tready;
            hd = a_tdata;
            if (a_tvalid && a_tready) begin
                e = sbq.pop_front();
                checks++;
                if (a_tdata !== e.d || a_tuser[0] !== e.sof || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL lfsr_beat cyc%0d: got d=%h sof=%b last=%b, expected d=%h sof=%b last=%b",
                             cyc, a_tdata, a_tuser[0], a_tlast, e.d, e.sof, e.last);
                end
            end
            if (sbq.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sbq.size() != 0 || a_cnt !== 16'd3) begin
            failures++;
            $display("FAIL lfsr_done: left=%0d frame_cnt=%0d, required 0 and 3", sbq.size(), a_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midline;
        beat_t e;
        int cyc, stray;
        a_sel = 2'b00; a_cont = 1'b0; a_tready = 1'b1; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b1 || a_tvalid !== 1'b1 || a_tdata !== 8'h01) begin
            failures++;
            $display("FAIL midline_pre: busy=%b tvalid=%b tdata=%h, required 1 1 01", a_busy, a_tvalid, a_tdata);
        end
        a_rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_tvalid, a_tlast, a_busy, a_done} !== 4'b0 || a_tdata !== 8'h00 || a_tuser !== 1'b0 || a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midline_reset: tvalid=%b tlast=%b busy=%b done=%b tdata=%h cnt=%0d, required all zero",
                     a_tvalid, a_tlast, a_busy, a_done, a_tdata, a_cnt);
        end
        a_rstn = 1'b1;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_tvalid) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midline_stray: %0d beats after reset, required 0", stray);
        end
        @(posedge clk); #1;
        sbq.delete();
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                sbq.push_back('{8'(x), (x == 0 && y == 0), (x == AW - 1)});
        a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 0;
        while (sbq.size() > 0 && cyc < 50) begin
            @(negedge clk); cyc++;
            if (a_tvalid && a_tready) begin
                e = sbq.pop_front();
                checks++;
                if (a_tdata !== e.d || a_tuser[0] !== e.sof || a_tlast !== e.last) begin
                    failures++;
                    $display("FAIL midline_restart cyc%0d: got d=%h sof=%b last=%b, expected d=%h sof=%b last=%b",
                             cyc, a_tdata, a_tuser[0], a_tlast, e.d, e.sof, e.last);
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sbq.size() != 0 || a_cnt !== 16'd1) begin
            failures++;
            $display("FAIL midline_count: left=%0d frame_cnt=%0d, required 0 and 1", sbq.size(), a_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_checker;
        beat_t e;
        int cyc;
        sbq.delete();
        for (int y = 0; y < BHT; y++)
            for (int x = 0; x < BWD; x++)
                sbq.push_back('{((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00, (x == 0 && y == 0), (x == BWD - 1)});
        b_sel = 2'b10; b_cont = 1'b0; b_tready = 1'b1; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cyc = 0;
        while (sbq.size() > 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (b_tvalid && b_tready) begin
                e = sbq.pop_front();
                checks++;
                if (b_tdata !== {2'b00, e.d} || b_tuser !== {1'b0, e.sof} || b_tlast !== e.last) begin
                    failures++;
                    $display("FAIL checker_beat cyc%0d: got d=%h u=%b last=%b, expected d=%h u=%b last=%b",
                             cyc, b_tdata, b_tuser, b_tlast, {2'b00, e.d}, {1'b0, e.sof}, e.last);
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sbq.size() != 0 || b_done !== 1'b1 || b_cnt !== 16'd1) begin
            failures++;
            $display("FAIL checker_done: left=%0d frame_done=%b frame_cnt=%0d, required 0 1 1", sbq.size(), b_done, b_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        beat_t e;
        int cyc, beats, frames, gap, stray;
        logic measuring;
        b_rstn = 1'b0;
        @(posedge clk); #1 b_rstn = 1'b1;
        sbq.delete();
        for (int f = 0; f < 3; f++)
            for (int y = 0; y < BHT; y++)
                for (int x = 0; x < BWD; x++)
                    sbq.push_back('{8'(x), (x == 0 && y == 0), (x == BWD - 1)});
        b_sel = 2'b00; b_cont = 1'b1; b_tready = 1'b1; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cyc = 0; beats = 0; frames = 0; gap = 0; measuring = 1'b0;
        while (sbq.size() > 0 && cyc < 1200) begin
            @(negedge clk); cyc++;
            if (b_done) begin
                frames++;
                checks++;
                if (b_cnt !== 16'(frames) || b_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_count: frame_cnt=%0d busy=%b, required %0d and 1", b_cnt, b_busy, frames);
                end
            end
            if (measuring) begin
                if (!b_tvalid) gap++;
                else begin
                    checks++;
                    if (gap != BHB) begin
                        failures++;
                        $display("FAIL b2b_gap at beat %0d: %0d idle cycles, required %0d", beats, gap, BHB);
                    end
                    measuring = 1'b0;
                end
            end
            if (b_tvalid && b_tready) begin
                e = sbq.pop_front();
                checks++;
                if (b_tdata !== {2'b00, e.d} || b_tuser !== {1'b0, e.sof} || b_tlast !== e.last) begin
                    failures++;
                    $display("FAIL b2b_beat %0d: got d=%h u=%b last=%b, expected d=%h u=%b last=%b",
                             beats, b_tdata, b_tuser, b_tlast, {2'b00, e.d}, {1'b0, e.sof}, e.last);
                end
                beats++;
                if (b_tlast) begin
                    measuring = 1'b1;
                    gap = 0;
                end
                if (beats == 2 * BWD * BHT + 100) b_cont = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sbq.size() != 0 || frames != 2 || b_done !== 1'b1 || b_cnt !== 16'd3) begin
            failures++;
            $display("FAIL b2b_final: left=%0d mid-run dones=%0d frame_done=%b frame_cnt=%0d, required 0 2 1 3",
                     sbq.size(), frames, b_done, b_cnt);
        end
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (b_tvalid || b_busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL b2b_idle: %0d active cycles after final frame, required 0", stray);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        a_rstn = 1'b0; a_start = 1'b0; a_cont = 1'b0; a_tready = 1'b0; a_sel = 2'b00; a_seed = 16'h0000;
        b_rstn = 1'b0; b_start = 1'b0; b_cont = 1'b0; b_tready = 1'b0; b_sel = 2'b00; b_seed = 16'h0000;
        test_reset();
        test_hramp();
        test_vramp_backpressure();
        test_lfsr_stall();
        test_reset_midline();
        test_checker();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
